sram_arbiter: RTL and testbench

- Two-requester arbiter in front of the single-word SRAM controller: shares one 32-bit read/write transaction port between port 0 (MEM stage) and port 1 (secondary master, e.g. instruction fetch or loader).
- Latches the winning request, holds the controller enables stable until the controller's ready is seen, and returns read data and a per-port ready.
- Per-port ready follows the same freeze semantics as the controller's ready: high when idle, low while a request is pending.

---
 rtl/sram_arbiter.sv | 175 +++++++++++++++++
 tb/tb_sram_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port arbiter in front of a single-word SRAM controller.
// Port 0 (MEM stage) and port 1 (secondary master) share one registered
// read/write transaction port. Each transaction runs IDLE -> BUSY -> DONE.
// Optional build macro SRAM_ARB_FIXED_PRIO_EN: ties always go to port 0
// (port 1 may starve); otherwise ties alternate round-robin.
module sram_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_wr_en,
  input  logic        p0_rd_en,
  input  logic [31:0] p0_address,
  input  logic [31:0] p0_write_data,
  output logic [31:0] p0_read_data,
  output logic        p0_ready,
  input  logic        p1_wr_en,
  input  logic        p1_rd_en,
  input  logic [31:0] p1_address,
  input  logic [31:0] p1_write_data,
  output logic [31:0] p1_read_data,
  output logic        p1_ready,
  output logic        mem_write_en,
  output logic        mem_read_en,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  input  logic        mem_ready,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  // Last BUSY cycle index before the transaction is abandoned.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        mem_wr_q, mem_wr_d;
  logic        mem_rd_q, mem_rd_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]  grant_q, grant_d;
  logic [31:0] p0_rdata_q, p0_rdata_d;
  logic [31:0] p1_rdata_q, p1_rdata_d;
  logic        tmo_err_q, tmo_err_d;
  logic [7:0]  cnt_q, cnt_d;
`ifndef SRAM_ARB_FIXED_PRIO_EN
  logic        rr_last_q, rr_last_d;
`endif

  logic req0, req1, pick1;

  assign req0 = p0_wr_en | p0_rd_en;
  assign req1 = p1_wr_en | p1_rd_en;

  // Winner selection: a lone requester wins; ties depend on the build option.
`ifdef SRAM_ARB_FIXED_PRIO_EN
  assign pick1 = req1 & ~req0;
`else
  assign pick1 = req1 & (~req0 | ~rr_last_q);
`endif

  // Next-state and datapath capture for the transaction sequencer.
  always_comb begin
    state_d     = state_q;
    mem_wr_d    = mem_wr_q;
    mem_rd_d    = mem_rd_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    grant_d     = grant_q;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
    tmo_err_d   = tmo_err_q;
    cnt_d       = cnt_q;
`ifndef SRAM_ARB_FIXED_PRIO_EN
    rr_last_d   = rr_last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          if (pick1) begin
            mem_wr_d    = p1_wr_en;
            mem_rd_d    = ~p1_wr_en;
            mem_addr_d  = p1_address;
            mem_wdata_d = p1_write_data;
            grant_d     = 2'b10;
          end else begin
            mem_wr_d    = p0_wr_en;
            mem_rd_d    = ~p0_wr_en;
            mem_addr_d  = p0_address;
            mem_wdata_d = p0_write_data;
            grant_d     = 2'b01;
          end
`ifndef SRAM_ARB_FIXED_PRIO_EN
          rr_last_d = pick1;
`endif
          cnt_d   = 8'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          if (mem_rd_q) begin
            if (grant_q[1]) p1_rdata_d = mem_read_data;
            else            p0_rdata_d = mem_read_data;
          end
          mem_wr_d = 1'b0;
          mem_rd_d = 1'b0;
          state_d  = DONE;
        end else if (cnt_q == TMO_LAST) begin
          tmo_err_d = 1'b1;
          mem_wr_d  = 1'b0;
          mem_rd_d  = 1'b0;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        // Enables are already low here, so the controller sees one idle cycle.
        grant_d = 2'b00;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_wr_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      grant_q     <= 2'b00;
      p0_rdata_q  <= 32'd0;
      p1_rdata_q  <= 32'd0;
      tmo_err_q   <= 1'b0;
      cnt_q       <= 8'd0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
      rr_last_q   <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      mem_wr_q    <= mem_wr_d;
      mem_rd_q    <= mem_rd_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      grant_q     <= grant_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
      tmo_err_q   <= tmo_err_d;
      cnt_q       <= cnt_d;
`ifndef SRAM_ARB_FIXED_PRIO_EN
      rr_last_q   <= rr_last_d;
`endif
    end
  end

  assign mem_write_en   = mem_wr_q;
  assign mem_read_en    = mem_rd_q;
  assign mem_address    = mem_addr_q;
  assign mem_write_data = mem_wdata_q;
  assign grant          = grant_q;
  assign timeout_err    = tmo_err_q;
  assign p0_read_data   = p0_rdata_q;
  assign p1_read_data   = p1_rdata_q;

  // A requesting port is frozen until its own DONE cycle.
  assign p0_ready = ~req0 | ((state_q == DONE) & grant_q[0]);
  assign p1_ready = ~req1 | ((state_q == DONE) & grant_q[1]);

endmodule

// File: tb/tb_sram_arbiter.sv
// Testbench for sram_arbiter: directed stimulus, scoreboard of expected
// transactions checked by a negedge monitor, simple SRAM controller model.
module tb_sram_arbiter;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_wr_en, p0_rd_en, p1_wr_en, p1_rd_en;
  logic [31:0] p0_address, p0_write_data, p1_address, p1_write_data;
  logic [31:0] p0_read_data, p1_read_data;
  logic        p0_ready, p1_ready;
  logic        mem_write_en, mem_read_en;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_ready;
  logic [1:0]  grant;
  logic        timeout_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .p0_wr_en(p0_wr_en), .p0_rd_en(p0_rd_en), .p0_address(p0_address),
    .p0_write_data(p0_write_data), .p0_read_data(p0_read_data), .p0_ready(p0_ready),
    .p1_wr_en(p1_wr_en), .p1_rd_en(p1_rd_en), .p1_address(p1_address),
    .p1_write_data(p1_write_data), .p1_read_data(p1_read_data), .p1_ready(p1_ready),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .mem_ready(mem_ready),
    .grant(grant), .timeout_err(timeout_err)
  );

  // ---------------- SRAM controller model ----------------
  int          mem_lat = 2;
  logic        mem_hang = 1'b0;
  int          lat_cnt = 0;
  logic        wr_vld = 1'b0;
  logic [31:0] wr_addr = 32'd0;
  logic [31:0] wr_data = 32'd0;

  always @(posedge clk) begin
    if (rst || !(mem_write_en || mem_read_en)) lat_cnt <= 0;
    else lat_cnt <= lat_cnt + 1;
    if (rst) wr_vld <= 1'b0;
    else if (mem_write_en && mem_ready) begin
      wr_vld  <= 1'b1;
      wr_addr <= mem_address;
      wr_data <= mem_write_data;
    end
  end

  always_comb begin
    mem_ready = !(mem_write_en || mem_read_en) || (!mem_hang && lat_cnt >= mem_lat);
    if (wr_vld && wr_addr == mem_address) mem_read_data = wr_data;
    else if (mem_address == 32'h100)      mem_read_data = 32'h1111_1111;
    else if (mem_address == 32'h200)      mem_read_data = 32'h2222_2222;
    else                                  mem_read_data = 32'hA5A5_0000 | {16'd0, mem_address[15:0]};
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [1:0]  gnt;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        tmo;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_rd0 = 32'd0;
  logic [31:0] exp_rd1 = 32'd0;
  logic        exp_tmo = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input int port, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] rdval,
                      input logic tmo_hit);
    exp_t e;
    e.gnt = (port == 1) ? 2'b10 : 2'b01;
    e.wr = wr;
    e.addr = addr;
    e.wdata = wdata;
    if (tmo_hit) exp_tmo = 1'b1;
    if (!wr && !tmo_hit) begin
      if (port == 1) exp_rd1 = rdval;
      else           exp_rd0 = rdval;
    end
    e.rdata = (port == 1) ? exp_rd1 : exp_rd0;
    e.tmo = exp_tmo;
    sb.push_back(e);
  endtask

  // Monitor: checks BUSY cycles against the head entry, pops on DONE.
  logic prev_done = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_done) chk("idle_after_done", {29'd0, grant, mem_write_en | mem_read_en}, 32'd0);
      prev_done = 1'b0;
      if (mem_write_en || mem_read_en) begin
        chk("busy_sb_pending", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          mon_e = sb[0];
          chk("busy_grant", {30'd0, grant}, {30'd0, mon_e.gnt});
          chk("busy_op", {30'd0, mem_write_en, mem_read_en}, {30'd0, mon_e.wr, ~mon_e.wr});
          chk("busy_addr", mem_address, mon_e.addr);
          if (mon_e.wr) chk("busy_wdata", mem_write_data, mon_e.wdata);
          chk("busy_p0_ready", {31'd0, p0_ready}, {31'd0, ~(p0_wr_en | p0_rd_en)});
          chk("busy_p1_ready", {31'd0, p1_ready}, {31'd0, ~(p1_wr_en | p1_rd_en)});
        end
      end else if (grant != 2'b00) begin
        prev_done = 1'b1;
        chk("done_sb_pending", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          chk("done_grant", {30'd0, grant}, {30'd0, mon_e.gnt});
          chk("done_ready", {31'd0, mon_e.gnt[1] ? p1_ready : p0_ready}, 32'd1);
          chk("done_rdata", mon_e.gnt[1] ? p1_read_data : p0_read_data, mon_e.rdata);
          chk("done_tmo", {31'd0, timeout_err}, {31'd0, mon_e.tmo});
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    p0_wr_en = 0; p0_rd_en = 0; p1_wr_en = 0; p1_rd_en = 0;
    sb.delete();
    exp_rd0 = 32'd0; exp_rd1 = 32'd0; exp_tmo = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Holds requests until port 0 and port 1 have seen n0/n1 DONE cycles.
  task automatic drive_until(input int n0, input int n1, input int budget);
    int d0 = 0;
    int d1 = 0;
    int cyc = 0;
    while ((d0 < n0 || d1 < n1) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (!mem_write_en && !mem_read_en && grant == 2'b01) d0++;
      if (!mem_write_en && !mem_read_en && grant == 2'b10) d1++;
      #1;
      if (d0 >= n0) begin p0_wr_en = 0; p0_rd_en = 0; end
      if (d1 >= n1) begin p1_wr_en = 0; p1_rd_en = 0; end
    end
    chk("txn_completed_in_budget", 32'(d0 >= n0 && d1 >= n1), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy;
    logic done_seen;
    rst = 1'b1;
    p0_wr_en = 0; p0_rd_en = 0; p1_wr_en = 0; p1_rd_en = 0;
    p0_address = 0; p0_write_data = 0; p1_address = 0; p1_write_data = 0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_en", {30'd0, mem_write_en, mem_read_en}, 32'd0);
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_addr", mem_address, 32'd0);
    chk("rst_wdata", mem_write_data, 32'd0);
    chk("rst_rdata0", p0_read_data, 32'd0);
    chk("rst_rdata1", p1_read_data, 32'd0);
    chk("rst_tmo", {31'd0, timeout_err}, 32'd0);
    chk("rst_ready", {30'd0, p0_ready, p1_ready}, 32'd3);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single write (both enables high: write wins), then read back
    p0_wr_en = 1; p0_rd_en = 1; p0_address = 32'h400; p0_write_data = 32'hDEADBEEF;
    push(0, 1'b1, 32'h400, 32'hDEADBEEF, 32'd0, 1'b0);
    @(negedge clk);
    chk("wr_en_not_before_sample", {31'd0, mem_write_en}, 32'd0);
    @(negedge clk);
    chk("wr_en_one_cycle_after", {31'd0, mem_write_en}, 32'd1);
    drive_until(1, 0, 50);
    @(posedge clk); #1;
    p0_rd_en = 1; p0_address = 32'h400;
    push(0, 1'b0, 32'h400, 32'd0, 32'hDEADBEEF, 1'b0);
    drive_until(1, 0, 50);
    @(negedge clk);
    chk("rdata_hold_p0", p0_read_data, 32'hDEADBEEF);

    // Simultaneous reads after reset
    do_reset();
    p0_rd_en = 1; p0_address = 32'h100;
    p1_rd_en = 1; p1_address = 32'h200;
    push(0, 1'b0, 32'h100, 32'd0, 32'h1111_1111, 1'b0);
    push(1, 1'b0, 32'h200, 32'd0, 32'h2222_2222, 1'b0);
    drive_until(1, 1, 100);

    // Sustained contention
    @(posedge clk); #1;
    p0_rd_en = 1; p0_address = 32'h100;
    p1_rd_en = 1; p1_address = 32'h200;
`ifdef SRAM_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++) push(0, 1'b0, 32'h100, 32'd0, 32'h1111_1111, 1'b0);
    push(1, 1'b0, 32'h200, 32'd0, 32'h2222_2222, 1'b0);
    drive_until(4, 1, 300);
`else
    for (int i = 0; i < 2; i++) begin
      push(0, 1'b0, 32'h100, 32'd0, 32'h1111_1111, 1'b0);
      push(1, 1'b0, 32'h200, 32'd0, 32'h2222_2222, 1'b0);
    end
    drive_until(2, 2, 300);
`endif
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // Idle ports
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_en", {30'd0, mem_write_en, mem_read_en}, 32'd0);
      chk("idle_ready", {30'd0, p0_ready, p1_ready}, 32'd3);
    end

    // Timeout: controller never answers
    @(posedge clk); #1;
    mem_hang = 1'b1;
    p0_rd_en = 1; p0_address = 32'h400;
    push(0, 1'b0, 32'h400, 32'd0, 32'd0, 1'b1);
    busy = 0;
    done_seen = 1'b0;
    for (int i = 0; i < 60 && !done_seen; i++) begin
      @(negedge clk);
      if (mem_write_en || mem_read_en) busy++;
      else if (grant != 2'b00) done_seen = 1'b1;
    end
    #1;
    p0_rd_en = 0;
    mem_hang = 1'b0;
    chk("tmo_done_reached", {31'd0, done_seen}, 32'd1);
    chk("tmo_busy_cycles", 32'(busy), 32'(TMO));
    repeat (3) @(negedge clk);
    chk("tmo_sticky", {31'd0, timeout_err}, 32'd1);
    chk("tmo_rdata_unchanged", p0_read_data, 32'h1111_1111);
    @(posedge clk); #1;
    p1_rd_en = 1; p1_address = 32'h200;
    push(1, 1'b0, 32'h200, 32'd0, 32'h2222_2222, 1'b0);
    drive_until(0, 1, 50);

    // Reset on the 3rd BUSY cycle
    @(posedge clk); #1;
    mem_lat = 10;
    p0_rd_en = 1; p0_address = 32'h100;
    push(0, 1'b0, 32'h100, 32'd0, 32'h1111_1111, 1'b0);
    busy = 0;
    for (int i = 0; i < 20 && busy < 3; i++) begin
      @(negedge clk);
      if (mem_write_en || mem_read_en) busy++;
    end
    chk("midrst_busy_reached", 32'(busy), 32'd3);
    #1;
    rst = 1'b1;
    p0_rd_en = 0;
    sb.delete();
    exp_rd0 = 32'd0; exp_rd1 = 32'd0; exp_tmo = 1'b0;
    @(negedge clk);
    chk("midrst_en", {30'd0, mem_write_en, mem_read_en}, 32'd0);
    chk("midrst_grant", {30'd0, grant}, 32'd0);
    chk("midrst_tmo", {31'd0, timeout_err}, 32'd0);
    chk("midrst_rdata0", p0_read_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_lat = 2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", {29'd0, grant, mem_write_en | mem_read_en}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
